uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter among NUM_REQ requesters with round-robin arbitration, one frame per grant. It sits between the requesting blocks and the transmitter. It accepts a byte from the winning requester, issues a one-cycle start to the transmitter, and tracks the transmitter's busy flag until the frame has finished on the line.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- BIT_WIDTH, 8: data bits per frame; must match the transmitter
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  bit i: requester i holds a byte
- req_data  in  NUM_REQ*BIT_WIDTH  requester i data in slice [i*BIT_WIDTH +: BIT_WIDTH]
- req_lock  in  NUM_REQ  bit i: requester i keeps the grant for its next frame (only with UART_ARB_LOCK_EN)
- req_ready  out  NUM_REQ  one-cycle pulse; requester i's byte accepted
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  BIT_WIDTH  byte for the transmitter; stable from tx_start until the next grant
- tx_busy  in  1  transmitter frame in progress
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- active  out  1  high from the grant until the frame completes

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set and tx_busy=0, select the winner: the first valid index scanning upward, with wrap, from last_grant+1.
  - Next edge: tx_data <= winner's slice, tx_start <= 1, req_ready[winner] <= 1, grant_id <= winner, active <= 1, state -> ISSUE.
- ISSUE: tx_start and req_ready return to 0; state -> WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then -> WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0, then -> IDLE, active <= 0, last_grant <= grant_id.
- Handshake with requesters:
  - Transfer happens in the cycle req_ready[i]=1.
  - Requester holds req_valid and data stable until it sees ready.
  - Requester may present its next byte from the following cycle.
  - Deasserting req_valid before ready withdraws the request; no byte is taken.
- tx_busy=1 while in IDLE (frame left over from before a reset) blocks all grants until it drops.
- Only one requester is granted per frame. req_ready is one-hot or zero.

## Timing
- Reset values: state IDLE, tx_start 0, tx_data 0, req_ready 0, grant_id 0, active 0, last_grant NUM_REQ-1, so requester 0 has first priority.
- Grant latency: req_valid seen in IDLE at cycle T gives tx_start and req_ready high in cycle T+1.
- Minimum gap: tx_busy falling at cycle T (sampled in WAIT_DONE) gives IDLE in T+1 and the next tx_start in T+2.
- Reset mid-frame: outputs clear immediately. The transmitter finishes its frame; the IDLE busy gate prevents overlap.
- Simultaneous valid on all requesters: grants rotate 0,1,2,...,NUM_REQ-1,0.
- Wrap: the pointer search wraps modulo NUM_REQ. Non-power-of-two NUM_REQ never yields an out-of-range index.

## Configuration
- UART_ARB_LOCK_EN defined:
  - req_lock port exists.
  - On return to IDLE, if req_lock[grant_id]=1 and req_valid[grant_id]=1, that requester wins again regardless of rotation. last_grant is not advanced.
  - The lock releases as soon as either signal is 0.
- Undefined: req_lock port is absent; pure round-robin.

## Structure
- Package uart_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE) and the default BIT_WIDTH constant, shared with the transmitter and receiver.
- Sub-module uart_rr_pick: combinational. Inputs are the valid vector and the last_grant pointer. Outputs are found and winner index. The FSM, registers and handshake stay in uart_tx_arbiter.

## Test plan
- Single request: req_valid=0001, data0=0x55 -> tx_start and req_ready[0] in the next cycle, tx_data=0x55, active high until tx_busy falls.
- All four valid, bytes 0xA0..0xA3 -> tx_data sequence A0,A1,A2,A3, each tx_start only after the prior busy falls. Gap from busy falling to next tx_start is 2 cycles.
- Requesters 1 and 3 valid, last_grant=1 -> 3 granted first, then 1.
- rst asserted while in WAIT_DONE with tx_busy=1, requester 2 valid -> outputs zero; no tx_start until tx_busy=0, then requester 0 priority applies, so requester 2 is granted.
- LOCK_EN: requester 1 with lock=1 and continuous valid, requester 2 valid -> three frames to 1; lock drops -> requester 2 is granted next.
- Withdraw: req_valid[3] pulsed for 1 cycle while the arbiter is in WAIT_DONE -> no req_ready[3], no tx_start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the default frame width.
// Used by the transmitter, the receiver and the transmit arbiter.
package uart_pkg;

  parameter int unsigned BitWidthDefault = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle     = 2'd0;
  localparam state_t StIssue    = 2'd1;
  localparam state_t StWaitBusy = 2'd2;
  localparam state_t StWaitDone = 2'd3;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner search: first set bit of valid_i scanning upward from
// last_i+1 with wrap modulo NUM_REQ. Purely combinational.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic                       found_o,
  output logic [$clog2(NUM_REQ)-1:0] winner_o
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    found_o  = 1'b0;
    winner_o = '0;
    // The modulo keeps every candidate in range for non-power-of-two NUM_REQ.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_i) + k) % NUM_REQ;
      if (!found_o && valid_i[idx]) begin
        found_o  = 1'b1;
        winner_o = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// one frame per grant. Define UART_ARB_LOCK_EN to add the req_lock grant hold.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIT_WIDTH = BitWidthDefault
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           req_lock,
`endif
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [BIT_WIDTH-1:0]         tx_data,
  input  logic                         tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic                 tx_start_q, tx_start_d;
  logic [BIT_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [IdW-1:0]       grant_id_q, grant_id_d;
  logic                 active_q, active_d;
  logic [IdW-1:0]       last_grant_q, last_grant_d;

  logic           rr_found;
  logic [IdW-1:0] rr_winner;
  logic           pick_found;
  logic [IdW-1:0] pick_id;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid_i  (req_valid),
    .last_i   (last_grant_q),
    .found_o  (rr_found),
    .winner_o (rr_winner)
  );

`ifdef UART_ARB_LOCK_EN
  // A locked, still-valid previous winner overrides the rotation.
  logic lock_hit;
  assign lock_hit   = req_lock[grant_id_q] & req_valid[grant_id_q];
  assign pick_found = lock_hit | rr_found;
  assign pick_id    = lock_hit ? grant_id_q : rr_winner;
`else
  assign pick_found = rr_found;
  assign pick_id    = rr_winner;
`endif

  always_comb begin
    state_d      = state_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    req_ready_d  = '0;
    grant_id_d   = grant_id_q;
    active_d     = active_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        // tx_busy gates grants so a frame surviving a reset is never overlapped.
        if (pick_found && !tx_busy) begin
          tx_data_d            = req_data[int'(pick_id) * BIT_WIDTH +: BIT_WIDTH];
          tx_start_d           = 1'b1;
          req_ready_d[pick_id] = 1'b1;
          grant_id_d           = pick_id;
          active_d             = 1'b1;
          state_d              = StIssue;
        end
      end
      StIssue: state_d = StWaitBusy;
      StWaitBusy: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d      = StIdle;
          active_d     = 1'b0;
          last_grant_d = grant_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      req_ready_q  <= '0;
      grant_id_q   <= '0;
      active_q     <= 1'b0;
      last_grant_q <= IdW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      req_ready_q  <= req_ready_d;
      grant_id_q   <= grant_id_d;
      active_q     <= active_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign req_ready = req_ready_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected (id, byte)
// grants plus a behavioural transmitter holding tx_busy for Frame cycles.
module tb_uart_tx_arbiter;

  localparam int NumReq = 4;
  localparam int Bw     = 8;
  localparam int Frame  = 6;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NumReq-1:0]    req_valid;
  logic [NumReq*Bw-1:0] req_data;
  logic [NumReq-1:0]    req_ready;
  logic                 tx_start;
  logic [Bw-1:0]        tx_data;
  logic                 tx_busy;
  logic [1:0]           grant_id;
  logic                 active;
`ifdef UART_ARB_LOCK_EN
  logic [NumReq-1:0]    req_lock;
`endif

  int   busy_cnt = 0;
  logic busy_force;

  exp_t        exp_q[$];
  logic [7:0]  src_data [NumReq][4];
  int          src_cnt [NumReq];
  int          src_idx [NumReq];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   starts = 0;
  int   fall_cyc = 0;
  bit   fall_valid = 0;
  bit   gap_en = 0;
  bit   prev_busy = 0;
  logic [NumReq-1:0] rdy_seen;

  uart_tx_arbiter #(
    .NUM_REQ   (NumReq),
    .BIT_WIDTH (Bw)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy starts the edge after tx_start and is not reset by rst.
  always @(posedge clk) begin
    if (tx_start === 1'b1) busy_cnt <= Frame;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || busy_force;

  task automatic expect_frame(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_src(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    src_data[i][0] = b0;
    src_data[i][1] = b1;
    src_data[i][2] = b2;
    src_data[i][3] = b3;
    src_cnt[i] = n;
    src_idx[i] = 0;
    req_data[i*Bw +: Bw] = b0;
    req_valid[i] = 1'b1;
  endtask

  // One clock: scoreboard the start pulse, then let requesters react to ready.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (prev_busy && !tx_busy) begin
      fall_cyc   = cyc;
      fall_valid = 1;
    end
    prev_busy = tx_busy;
    rdy_seen  = rdy_seen | req_ready;
    if (tx_start === 1'b1) begin
      starts++;
      if (gap_en && fall_valid) begin
        checks++;
        if (cyc - fall_cyc != 2) begin
          errors++;
          $display("FAIL gap: busy-fall to tx_start took %0d cycles, required 2", cyc - fall_cyc);
        end
      end
      fall_valid = 0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: grant_id=%0d tx_data=%h, required no tx_start",
                 grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        if (grant_id !== e.id || tx_data !== e.data || req_ready !== (4'b0001 << e.id)) begin
          errors++;
          $display("FAIL grant: id=%0d data=%h ready=%b, required id=%0d data=%h ready=%b",
                   grant_id, tx_data, req_ready, e.id, e.data, 4'b0001 << e.id);
        end
      end
    end else begin
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stray_ready: req_ready=%b without tx_start, required 0000", req_ready);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (req_ready[i] === 1'b1) begin
        src_idx[i]++;
        if (src_idx[i] < src_cnt[i]) req_data[i*Bw +: Bw] = src_data[i][src_idx[i]];
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run_until_drained(input int budget);
    int n;
    n = 0;
    while (!(req_valid == '0 && !active && !tx_busy && exp_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames still expected after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n;
    n = 0;
    while (starts < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (starts < target) begin
      errors++;
      $display("FAIL start_timeout: %0d starts seen, required %0d", starts, target);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0000 || grant_id !== 2'd0 ||
        active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: start=%b data=%h ready=%b id=%0d active=%b, required all 0",
               tx_start, tx_data, req_ready, grant_id, active);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    set_src(0, 1, 8'h55, 8'h00, 8'h00, 8'h00);
    expect_frame(2'd0, 8'h55);
    step();
    checks++;
    if (tx_start !== 1'b1 || active !== 1'b1) begin
      errors++;
      $display("FAIL latency: tx_start=%b active=%b one cycle after valid, required 1 1",
               tx_start, active);
    end
    step();
    n = 0;
    while (tx_busy && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL active_hold: active=%b in cycle busy first low, required 1", active);
    end
    step();
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL active_drop: active=%b after busy fell, required 0", active);
    end
    run_until_drained(100);
  endtask

  task automatic test_reset_mid_frame();
    set_src(0, 1, 8'h11, 8'h00, 8'h00, 8'h00);
    expect_frame(2'd0, 8'h11);
    wait_starts(starts + 1, 20);
    repeat (3) step();
    busy_force = 1'b1;
    set_src(2, 1, 8'h22, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0000 || grant_id !== 2'd0 ||
        active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: start=%b data=%h ready=%b id=%0d active=%b, required all 0",
               tx_start, tx_data, req_ready, grant_id, active);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tx_start !== 1'b0) begin
        errors++;
        $display("FAIL busy_gate: tx_start=%b while tx_busy held after reset, required 0",
                 tx_start);
      end
    end
    busy_force = 1'b0;
    expect_frame(2'd2, 8'h22);
    run_until_drained(100);
  endtask

  task automatic test_pair();
    set_src(1, 1, 8'h31, 8'h00, 8'h00, 8'h00);
    expect_frame(2'd1, 8'h31);
    run_until_drained(100);
    set_src(1, 1, 8'h41, 8'h00, 8'h00, 8'h00);
    set_src(3, 1, 8'h43, 8'h00, 8'h00, 8'h00);
    expect_frame(2'd3, 8'h43);
    expect_frame(2'd1, 8'h41);
    run_until_drained(100);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_src(0, 2, 8'hA0, 8'hB0, 8'h00, 8'h00);
    set_src(1, 1, 8'hA1, 8'h00, 8'h00, 8'h00);
    set_src(2, 1, 8'hA2, 8'h00, 8'h00, 8'h00);
    set_src(3, 1, 8'hA3, 8'h00, 8'h00, 8'h00);
    expect_frame(2'd0, 8'hA0);
    expect_frame(2'd1, 8'hA1);
    expect_frame(2'd2, 8'hA2);
    expect_frame(2'd3, 8'hA3);
    expect_frame(2'd0, 8'hB0);
    fall_valid = 0;
    gap_en     = 1;
    run_until_drained(200);
    gap_en = 0;
  endtask

  task automatic test_withdraw();
    int s0;
    rdy_seen = '0;
    s0 = starts;
    set_src(0, 1, 8'h77, 8'h00, 8'h00, 8'h00);
    expect_frame(2'd0, 8'h77);
    wait_starts(s0 + 1, 20);
    repeat (3) step();
    req_data[3*Bw +: Bw] = 8'h99;
    req_valid[3] = 1'b1;
    step();
    req_valid[3] = 1'b0;
    run_until_drained(100);
    checks++;
    if (rdy_seen[3] !== 1'b0 || starts - s0 != 1) begin
      errors++;
      $display("FAIL withdraw: ready3_seen=%b starts=%0d, required 0 and 1",
               rdy_seen[3], starts - s0);
    end
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    int s0;
    apply_reset();
    s0 = starts;
    req_lock = 4'b0010;
    set_src(1, 4, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    set_src(2, 1, 8'hE2, 8'h00, 8'h00, 8'h00);
    expect_frame(2'd1, 8'hD0);
    expect_frame(2'd1, 8'hD1);
    expect_frame(2'd1, 8'hD2);
    expect_frame(2'd2, 8'hE2);
    expect_frame(2'd1, 8'hD3);
    wait_starts(s0 + 3, 100);
    req_lock = 4'b0000;
    run_until_drained(200);
  endtask
`endif

  initial begin
    req_valid  = '0;
    req_data   = '0;
    busy_force = 1'b0;
    rdy_seen   = '0;
`ifdef UART_ARB_LOCK_EN
    req_lock   = '0;
`endif
    for (int i = 0; i < NumReq; i++) begin
      src_cnt[i] = 0;
      src_idx[i] = 0;
    end
    test_reset();
    test_single();
    test_reset_mid_frame();
    test_pair();
    test_back_to_back();
    test_withdraw();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
